vend_dispense_sequencer: RTL and testbench
==========================================

Name: vend_dispense_sequencer

Overview:
- Downstream consumer of the vending-machine state register's 4-bit state output (`sflipflop`).
- Interprets that state as accumulated credit in nickels.
- On reaching the price, drives the timed dispense-motor pulse, then emits one timed pulse per nickel of change owed.
- Runs entirely on the 50 MHz clock. The state input changes on the debounced button clock, so the block synchronizes and qualifies it before use.

Parameters:
- PRICE_NICKELS, 5: item price in nickels (1..15).
- DISPENSE_CYCLES, 25000000: width of the dispense pulse in clocks (0.5 s).
- PULSE_CYCLES, 5000000: width of each change_nickel pulse in clocks.
- GAP_CYCLES, 5000000: idle gap after dispense and after every change pulse, in clocks.

Ports:
- clock_50MHz, input, 1: sole clock, rising edge.
- async_Reset, input, 1: asynchronous, active-high reset.
- sflipflop, input, 4: current machine state = credit in nickels (0..15). Asynchronous to clock_50MHz.
- dispense, output, 1: dispense motor drive, high for DISPENSE_CYCLES.
- change_nickel, output, 1: coin-return solenoid, one pulse per nickel returned.
- busy, output, 1: high from trigger until rearm.
- vend_done, output, 1: single-cycle strobe when sequence completes.
- change_left, output, 4: nickels of change still to be returned.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizer and credit registers cleared to 0, counters 0. Reset takes effect immediately mid-sequence; no partial pulse continues.
- Input qualification:
  - sflipflop passes through a 2-flop synchronizer (s1, s2), then a third register s3.
  - credit_q loads s2 only when s2 == s3; otherwise it holds, which filters transitional multi-bit codes.
- Trigger: vend_req = (credit_q >= PRICE_NICKELS) && FSM in IDLE.
  - For a stable input change sampled first at edge k, dispense rises at edge k+4.
- On trigger, change_left loads credit_q - PRICE_NICKELS. Width is 4 bits and underflow is impossible by construction.
- Single down-counter, width $clog2(max(DISPENSE_CYCLES, PULSE_CYCLES, GAP_CYCLES)+1), reloaded on each state entry.
- FSM states: IDLE, DISPENSE, GAP_D, CHANGE, GAP_C, DONE, REARM.
  - IDLE -> DISPENSE on vend_req. busy=1, dispense=1.
  - DISPENSE: hold dispense for exactly DISPENSE_CYCLES clocks, then -> GAP_D (dispense=0).
  - GAP_D: GAP_CYCLES clocks, then -> CHANGE if change_left != 0, else -> DONE.
  - CHANGE: change_nickel=1 for exactly PULSE_CYCLES clocks. On exit, change_left decrements by 1 -> GAP_C.
  - GAP_C: GAP_CYCLES clocks, then -> CHANGE if change_left != 0, else -> DONE.
  - DONE: vend_done=1 for exactly one cycle -> REARM.
  - REARM: busy stays 1 until credit_q < PRICE_NICKELS, then -> IDLE and busy=0 on that edge.
- Credit changes during DISPENSE..DONE are ignored; change_left is fixed at trigger.
- REARM prevents a second vend off the same credit. A new vend needs credit to drop below price and rise again.
- credit_q == 15 with PRICE 5 gives change 10. Maximum change is 15 - PRICE_NICKELS.
- dispense and change_nickel are never high together. Both are registered, glitch-free outputs.

Decomposition:
- Package vend_pkg holds:
  - typedef credit_t (logic [3:0]);
  - enum vend_state_e with the 7 states;
  - default timing constants.
- Sub-module state_sync: 2-flop synchronizer plus stability compare producing credit_q. Reusable for other cross-domain state taps.
- Everything else is one FSM/counter module.

Test Plan:
- Parameters for all scenarios: PRICE=5, DISPENSE=8, PULSE=3, GAP=2.
- Exact price: reset, then drive sflipflop 0→5 stable. Required response:
  - dispense high 8 clocks, starting edge k+4;
  - no change_nickel;
  - vend_done one cycle after 2 gap clocks;
  - busy held until sflipflop returns to 0.
- Change return: sflipflop=8. Required response:
  - change_left loads 3;
  - after dispense + gap, three change_nickel pulses of 3 clocks, separated by 2-clock gaps;
  - change_left steps 3→2→1→0;
  - then vend_done.
- Maximum credit: sflipflop=15. Required response: 10 change pulses, change_left ends at 0, no wrap.
- Glitch filter: sflipflop toggles 0→7→0 for a single 50 MHz cycle. Required response: no trigger, busy stays 0. A held value of 7 does trigger.
- Rearm: hold sflipflop at 6 after vend_done. Required response:
  - no second dispense;
  - drop to 0, then 6 again, gives exactly one new sequence.
- Reset mid-op: assert async_Reset during the 2nd change pulse. Required response:
  - all outputs 0 in the same cycle, without waiting for a clock edge;
  - after release with sflipflop=6 held, a fresh sequence starts with change_left=1.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default timing for the vending dispense sequencer.
// The credit is the machine state itself: a 4-bit count of nickels.
package vend_pkg;

   typedef logic [3:0] credit_t;

   typedef enum logic [2:0] {
      IDLE,
      DISPENSE,
      GAP_D,
      CHANGE,
      GAP_C,
      DONE,
      REARM
   } vend_state_e;

   // Defaults assume a 50 MHz clock.
   localparam int DEF_PRICE_NICKELS   = 5;
   localparam int DEF_DISPENSE_CYCLES = 25_000_000;
   localparam int DEF_PULSE_CYCLES    = 5_000_000;
   localparam int DEF_GAP_CYCLES      = 5_000_000;

   // Sizes the shared down-counter so it can hold the longest interval.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/vend_dispense_sequencer_if.sv
// Bundles the state tap from the vending state register with the
// sequencer's actuator drives and status.
// master = state-register side, slave = dispense sequencer.
import vend_pkg::*;

interface vend_dispense_sequencer_if;

   credit_t sflipflop;
   logic    dispense;
   logic    change_nickel;
   logic    busy;
   logic    vend_done;
   credit_t change_left;

   modport master (
      output sflipflop,
      input  dispense,
      input  change_nickel,
      input  busy,
      input  vend_done,
      input  change_left
   );

   modport slave (
      input  sflipflop,
      output dispense,
      output change_nickel,
      output busy,
      output vend_done,
      output change_left
   );

endinterface

// File: rtl/vend_dispense_sequencer_state_sync.sv
// Brings a multi-bit state value from another clock domain into this one.
// Two flops resolve metastability. A third flop lets us see whether the
// value held still for a cycle. Only a value that matches its previous
// sample is passed on, so half-changed codes never reach q.
module state_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] s3;

   // Synchronizer chain plus stability-qualified capture of the value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
         if (s2 == s3) begin
            q <= s2;
         end
      end
   end

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Watches the vending machine's credit (its state register) and, once the
// price is reached, runs the dispense motor, then returns change one
// nickel at a time. It then waits for the credit to fall below the price
// before it can vend again.
import vend_pkg::*;

module vend_dispense_sequencer #(
   parameter int PRICE_NICKELS   = DEF_PRICE_NICKELS,
   parameter int DISPENSE_CYCLES = DEF_DISPENSE_CYCLES,
   parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
   parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
   input logic                      clock_50MHz,
   input logic                      async_Reset,
   vend_dispense_sequencer_if.slave bus
);

   localparam int MAX_CYCLES = max3(DISPENSE_CYCLES, PULSE_CYCLES, GAP_CYCLES);
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam credit_t          PRICE    = credit_t'(PRICE_NICKELS);
   localparam logic [CNT_W-1:0] LOAD_DSP = CNT_W'(DISPENSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_PLS = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_GAP = CNT_W'(GAP_CYCLES - 1);

   credit_t          credit_q;
   vend_state_e      state;
   vend_state_e      state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   credit_t          change_q;
   credit_t          change_n;
   logic             dispense_q;
   logic             change_nickel_q;
   logic             busy_q;
   logic             vend_done_q;

   state_sync #(
      .WIDTH(4)
   ) u_state_sync (
      .clk(clock_50MHz),
      .rst(async_Reset),
      .d  (bus.sflipflop),
      .q  (credit_q)
   );

   // Next-state logic. Each interval loads the counter with its length
   // minus one when the state is entered, and leaves the state when the
   // counter reaches zero. Change owed is fixed when the vend is triggered.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      change_n = change_q;
      case (state)
         IDLE: begin
            if (credit_q >= PRICE) begin
               state_n  = DISPENSE;
               cnt_n    = LOAD_DSP;
               change_n = credit_q - PRICE;
            end
         end
         DISPENSE: begin
            if (cnt == '0) begin
               state_n = GAP_D;
               cnt_n   = LOAD_GAP;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         GAP_D, GAP_C: begin
            if (cnt == '0) begin
               if (change_q != '0) begin
                  state_n = CHANGE;
                  cnt_n   = LOAD_PLS;
               end else begin
                  state_n = DONE;
               end
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         CHANGE: begin
            if (cnt == '0) begin
               state_n  = GAP_C;
               cnt_n    = LOAD_GAP;
               change_n = change_q - credit_t'(1);
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         DONE: begin
            state_n = REARM;
         end
         REARM: begin
            if (credit_q < PRICE) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, counter and output registers. The outputs are decoded from the
   // next state, so every drive changes on the same edge as its state and
   // leaves a flop with no glitches. Reset clears everything at once.
   always_ff @(posedge clock_50MHz or posedge async_Reset) begin
      if (async_Reset) begin
         state           <= IDLE;
         cnt             <= '0;
         change_q        <= '0;
         dispense_q      <= 1'b0;
         change_nickel_q <= 1'b0;
         busy_q          <= 1'b0;
         vend_done_q     <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         change_q        <= change_n;
         dispense_q      <= (state_n == DISPENSE);
         change_nickel_q <= (state_n == CHANGE);
         busy_q          <= (state_n != IDLE);
         vend_done_q     <= (state_n == DONE);
      end
   end

   assign bus.dispense      = dispense_q;
   assign bus.change_nickel = change_nickel_q;
   assign bus.busy          = busy_q;
   assign bus.vend_done     = vend_done_q;
   assign bus.change_left   = change_q;

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Bench for the vending dispense sequencer, using short timing parameters.
// A monitor measures each dispense, change and done pulse. It compares each
// pulse against the scoreboard queue that the scenario tasks fill when they
// drive a credit value.
module tb_vend_dispense_sequencer;
   import vend_pkg::*;

   localparam int PRICE = 5;
   localparam int DSP   = 8;
   localparam int PLS   = 3;
   localparam int GAP   = 2;

   typedef struct {
      int kind;
      int len;
      int cl;
      int gap;
   } ev_t;

   logic clock_50MHz;
   logic async_Reset;
   int   checks;
   int   failures;
   ev_t  exp_q[$];

   vend_dispense_sequencer_if bus();

   vend_dispense_sequencer #(
      .PRICE_NICKELS  (PRICE),
      .DISPENSE_CYCLES(DSP),
      .PULSE_CYCLES   (PLS),
      .GAP_CYCLES     (GAP)
   ) dut (
      .clock_50MHz(clock_50MHz),
      .async_Reset(async_Reset),
      .bus        (bus)
   );

   // 50 MHz-style free-running clock.
   initial begin
      clock_50MHz = 1'b0;
      forever #5 clock_50MHz = ~clock_50MHz;
   end

   // Ends the run if something hangs.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Pulse monitor. Kind 0 = dispense, 1 = change_nickel, 2 = vend_done.
   // On each falling edge it measures the pulse length, the change_left seen
   // at the rising edge, and the idle gap since the previous pulse ended,
   // then pops the next expected pulse and compares them.
   int   cyc = 0;
   int   last_end = -1;
   logic [2:0] prev = '0;
   int   start_c[3];
   int   start_cl[3];
   always @(negedge clock_50MHz) begin
      logic [2:0] cur;
      int         len;
      int         gap;
      ev_t        e;
      cyc++;
      cur = {bus.vend_done, bus.change_nickel, bus.dispense};
      if (async_Reset) begin
         prev     = '0;
         last_end = -1;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (cur[k] && !prev[k]) begin
               start_c[k]  = cyc;
               start_cl[k] = int'(bus.change_left);
            end
            if (!cur[k] && prev[k]) begin
               len      = cyc - start_c[k];
               gap      = (last_end < 0) ? -1 : start_c[k] - last_end;
               last_end = cyc;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("[TB] FAIL unexpected_pulse kind=%0d len=%0d, none required", k, len);
               end else begin
                  e = exp_q.pop_front();
                  checks++;
                  if (k !== e.kind) begin
                     failures++;
                     $display("[TB] FAIL pulse_kind got=%0d want=%0d", k, e.kind);
                  end
                  checks++;
                  if (len !== e.len) begin
                     failures++;
                     $display("[TB] FAIL pulse_len kind=%0d got=%0d want=%0d", k, len, e.len);
                  end
                  checks++;
                  if (start_cl[k] !== e.cl) begin
                     failures++;
                     $display("[TB] FAIL change_left kind=%0d got=%0d want=%0d", k, start_cl[k], e.cl);
                  end
                  if (e.gap >= 0) begin
                     checks++;
                     if (gap !== e.gap) begin
                        failures++;
                        $display("[TB] FAIL pulse_gap kind=%0d got=%0d want=%0d", k, gap, e.gap);
                     end
                  end
               end
            end
         end
         prev = cur;
      end
   end

   // Queues the full pulse sequence that a vend at this credit should produce.
   function automatic void push_vend(input int credit);
      int   chg;
      ev_t  e;
      chg = credit - PRICE;
      e = '{kind: 0, len: DSP, cl: chg, gap: -1};
      exp_q.push_back(e);
      for (int n = chg; n >= 1; n--) begin
         e = '{kind: 1, len: PLS, cl: n, gap: GAP};
         exp_q.push_back(e);
      end
      e = '{kind: 2, len: 1, cl: 0, gap: GAP};
      exp_q.push_back(e);
   endfunction

   // Drives a credit value just after a falling edge. Reports how many edges
   // after the first sampling edge dispense rose, and change_left at that point.
   task automatic start_vend(input int credit, input bit push, input bit release_rst,
                             output int lat, output int cl);
      @(negedge clock_50MHz);
      bus.sflipflop = credit_t'(credit);
      if (release_rst) async_Reset = 1'b0;
      if (push) push_vend(credit);
      lat = -1;
      cl  = -1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock_50MHz);
         #1;
         if (bus.dispense && lat < 0) begin
            lat = i;
            cl  = int'(bus.change_left);
         end
      end
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock_50MHz);
         #1;
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock_50MHz);
         #1;
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Drops the credit to 0 and expects busy to clear within the budget.
   task automatic release_credit(input string name);
      bit ok;
      @(negedge clock_50MHz);
      bus.sflipflop = '0;
      wait_idle(20, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL %s_idle busy stayed high, required low", name);
      end
   endtask

   task automatic test_reset();
      logic [7:0] outs;
      async_Reset   = 1'b1;
      bus.sflipflop = '0;
      repeat (3) @(negedge clock_50MHz);
      outs = {bus.dispense, bus.change_nickel, bus.busy, bus.vend_done, bus.change_left};
      checks++;
      if (outs !== 8'h00) begin
         failures++;
         $display("[TB] FAIL reset_outputs got=%h want=00", outs);
      end
      async_Reset = 1'b0;
      repeat (6) @(negedge clock_50MHz);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_idle busy got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_exact_price();
      int lat;
      int cl;
      bit ok;
      start_vend(5, 1'b1, 1'b0, lat, cl);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("[TB] FAIL exact_latency got=%0d want=4", lat);
      end
      checks++;
      if (cl !== 0) begin
         failures++;
         $display("[TB] FAIL exact_change got=%0d want=0", cl);
      end
      wait_drain(40, ok);
      checks++;
      if (!ok) begin
         failures++;
         exp_q.delete();
         $display("[TB] FAIL exact_drain sequence incomplete, required complete");
      end
      repeat (10) @(negedge clock_50MHz);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL exact_rearm_busy got=%b want=1", bus.busy);
      end
      @(negedge clock_50MHz);
      bus.sflipflop = '0;
      repeat (4) @(posedge clock_50MHz);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL exact_busy_k3 got=%b want=1", bus.busy);
      end
      @(posedge clock_50MHz);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL exact_busy_k4 got=%b want=0", bus.busy);
      end
   endtask

   task automatic test_change_return(input int credit, input string name, input int budget);
      int lat;
      int cl;
      bit ok;
      start_vend(credit, 1'b1, 1'b0, lat, cl);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("[TB] FAIL %s_latency got=%0d want=4", name, lat);
      end
      checks++;
      if (cl !== credit - PRICE) begin
         failures++;
         $display("[TB] FAIL %s_load got=%0d want=%0d", name, cl, credit - PRICE);
      end
      wait_drain(budget, ok);
      checks++;
      if (!ok) begin
         failures++;
         exp_q.delete();
         $display("[TB] FAIL %s_drain sequence incomplete, required complete", name);
      end
      checks++;
      if (bus.change_left !== 4'd0) begin
         failures++;
         $display("[TB] FAIL %s_final_change got=%0d want=0", name, bus.change_left);
      end
      release_credit(name);
   endtask

   task automatic test_glitch();
      int busy_seen;
      int lat;
      int cl;
      bit ok;
      busy_seen = 0;
      @(negedge clock_50MHz);
      bus.sflipflop = 4'd7;
      @(negedge clock_50MHz);
      bus.sflipflop = 4'd0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock_50MHz);
         if (bus.busy) busy_seen++;
      end
      checks++;
      if (busy_seen !== 0) begin
         failures++;
         $display("[TB] FAIL glitch_busy got=%0d busy cycles want=0", busy_seen);
      end
      start_vend(7, 1'b1, 1'b0, lat, cl);
      checks++;
      if (lat !== 4 || cl !== 2) begin
         failures++;
         $display("[TB] FAIL glitch_held got lat=%0d cl=%0d want lat=4 cl=2", lat, cl);
      end
      wait_drain(60, ok);
      checks++;
      if (!ok) begin
         failures++;
         exp_q.delete();
         $display("[TB] FAIL glitch_drain sequence incomplete, required complete");
      end
      release_credit("glitch");
   endtask

   task automatic test_rearm();
      int lat;
      int cl;
      bit ok;
      int low_seen;
      for (int pass = 0; pass < 2; pass++) begin
         start_vend(6, 1'b1, 1'b0, lat, cl);
         checks++;
         if (lat !== 4 || cl !== 1) begin
            failures++;
            $display("[TB] FAIL rearm_start%0d got lat=%0d cl=%0d want lat=4 cl=1", pass, lat, cl);
         end
         wait_drain(60, ok);
         checks++;
         if (!ok) begin
            failures++;
            exp_q.delete();
            $display("[TB] FAIL rearm_drain%0d sequence incomplete, required complete", pass);
         end
         low_seen = 0;
         for (int i = 0; i < 25; i++) begin
            @(negedge clock_50MHz);
            if (!bus.busy || bus.dispense) low_seen++;
         end
         checks++;
         if (low_seen !== 0) begin
            failures++;
            $display("[TB] FAIL rearm_hold%0d got=%0d idle/dispense cycles want=0", pass, low_seen);
         end
         release_credit("rearm");
      end
   endtask

   task automatic test_reset_midop();
      ev_t        e;
      bit         found;
      int         lat;
      int         cl;
      bit         ok;
      logic [7:0] outs;
      e = '{kind: 0, len: DSP, cl: 3, gap: -1};
      exp_q.push_back(e);
      e = '{kind: 1, len: PLS, cl: 3, gap: GAP};
      exp_q.push_back(e);
      start_vend(8, 1'b0, 1'b0, lat, cl);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock_50MHz);
         if (bus.change_nickel && bus.change_left == 4'd2) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL midop_second_pulse not seen, required seen");
      end
      @(posedge clock_50MHz);
      #2;
      async_Reset = 1'b1;
      #1;
      outs = {bus.dispense, bus.change_nickel, bus.busy, bus.vend_done, bus.change_left};
      checks++;
      if (outs !== 8'h00) begin
         failures++;
         $display("[TB] FAIL midop_async_clear got=%h want=00", outs);
      end
      bus.sflipflop = 4'd6;
      repeat (2) @(negedge clock_50MHz);
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL midop_pulses_before_reset got=%0d pending want=0", exp_q.size());
         exp_q.delete();
      end
      start_vend(6, 1'b1, 1'b1, lat, cl);
      checks++;
      if (lat !== 4 || cl !== 1) begin
         failures++;
         $display("[TB] FAIL midop_restart got lat=%0d cl=%0d want lat=4 cl=1", lat, cl);
      end
      wait_drain(60, ok);
      checks++;
      if (!ok) begin
         failures++;
         exp_q.delete();
         $display("[TB] FAIL midop_drain sequence incomplete, required complete");
      end
      release_credit("midop");
   endtask

   // Runs the scenarios in order and prints the summary.
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_exact_price();
      test_change_return(8, "change", 80);
      test_change_return(15, "maxcredit", 120);
      test_glitch();
      test_rearm();
      test_reset_midop();
      repeat (5) @(negedge clock_50MHz);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
